rr_bus_arbiter: RTL and testbench
=================================

# rr_bus_arbiter

Round-robin arbiter and transaction sequencer for the serial system bus. It shares one bus between `N_MASTERS` requesters and grants one master at a time. It deserialises the slave index from the granted master's serial address line, then routes the serial write/read data bits between that master and the selected slave. It also signals completion and any error back to the master. The block sits between the master ports and the slave ports and replaces ad-hoc fixed-priority granting.

## Interface
- `N_MASTERS`, 2: number of requesting masters (≥2).
- `N_SLAVES`, 3: number of slaves; valid slave indices are 0..N_SLAVES-1.
- `SLAVE_ADDR_W`, 2: serial slave-index bits, MSB first; ≥ clog2(N_SLAVES).
- `DATA_W`, 8: data bits per transaction.
- `TIMEOUT`, 15: maximum consecutive stalled DATA cycles before an error.

- `clk`, in, 1: clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `m_breq`, in, N_MASTERS: bus request, one bit per master; held high for the whole transaction.
- `m_addr`, in, N_MASTERS: serial slave-index bit per master.
- `m_write`, in, N_MASTERS: 1 = write, 0 = read; sampled on the first ADDR cycle.
- `m_wdata`, in, N_MASTERS: serial write-data bit per master.
- `m_grant`, out, N_MASTERS: one-hot grant, registered.
- `m_rdata`, out, N_MASTERS: serial read data; only the granted master's bit follows `s_rdata`, all others are 0.
- `m_ready`, out, N_MASTERS: one-cycle completion pulse to the granted master.
- `m_resp`, out, 2: 2'b00 OKAY, 2'b01 timeout error, 2'b10 decode error; valid only while `m_ready` is high, otherwise 0.
- `s_select`, out, N_SLAVES: one-hot slave select, high only in DATA.
- `s_write`, out, 1: latched `m_write`; high only in DATA.
- `s_wdata`, out, 1: granted master's `m_wdata`; high only in DATA.
- `s_rdata`, in, N_SLAVES: serial read-data bit per slave.
- `s_ready`, in, N_SLAVES: per-slave bit-accept/bit-valid strobe.

## Operation
- States: IDLE → ADDR → DATA → DONE → IDLE.
- **IDLE**
  - Search `m_breq` in order `last+1, last+2, …` with wrap-around; the first requester found wins.
  - On a hit: load `cur`, set `m_grant[cur]`, clear the address bit counter, go to ADDR.
  - `last` resets to N_MASTERS-1, so master 0 wins the first arbitration.
- **ADDR**
  - Runs for SLAVE_ADDR_W cycles.
  - Each cycle shifts `m_addr[cur]` into `slave_idx`, MSB first.
  - The first ADDR cycle also latches `m_write[cur]`.
  - After the last bit:
    - `slave_idx` < N_SLAVES → DATA.
    - Otherwise → DONE with decode error; no slave is selected.
- **DATA**
  - `s_select[slave_idx]` = 1.
  - A bit transfers in each cycle where `s_ready[slave_idx]` = 1; the bit counter increments.
  - Write: `s_wdata` = `m_wdata[cur]`.
  - Read: `m_rdata[cur]` = `s_rdata[slave_idx]`.
  - The master advances its wdata bit only on a cycle where the slave's `s_ready` is high.
  - After DATA_W transferred bits → DONE with OKAY.
- **DONE**
  - Lasts exactly one cycle: `m_ready[cur]` = 1 and `m_resp` = the latched response.
  - `m_grant[cur]` stays high through DONE and drops on entry to IDLE.
  - `last` ← `cur`.
- **Abort:** if `m_breq[cur]` falls in ADDR or DATA, go to IDLE on the next edge.
  - Grant drops, no `m_ready` pulse is issued, `last` ← `cur`.
- **Counters:**
  - The bit counter is clog2(DATA_W+1) wide and never wraps.
  - The stall counter is clog2(TIMEOUT+1) wide and saturates.
- **Reset:** async reset, including mid-transaction, forces IDLE immediately.
  - All outputs go to 0 and all counters clear.

## Timing
- Request sampled in IDLE at edge T; `m_grant` is high from T+1.
- The first ADDR cycle is T+1 to T+2, and the master must drive its address MSB during it.
- Unstalled transaction: 1 IDLE + SLAVE_ADDR_W + DATA_W + 1 DONE cycles; default = 12 cycles from request to grant release.
- `s_select`, `s_write`, `s_wdata`, `m_rdata` are combinational from state and registered indices; they carry no added latency.
- Back-to-back: the next arbitration occurs in the IDLE cycle after DONE, so there is always at least 1 idle bus cycle.
- Requests arriving during a transaction are ignored until IDLE.
- If requests are simultaneous, round-robin order decides; ties are impossible.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The stall counter counts consecutive DATA cycles with `s_ready[slave_idx]` = 0 and clears on any ready cycle.
  - On reaching TIMEOUT it goes to DONE with `m_resp` = 2'b01.
- `ARB_TIMEOUT_EN` undefined: no stall counter; DATA waits indefinitely and resp 2'b01 is never produced.

## Test plan
- Reset, then m_breq=2'b01, addr bits 1,0, write, 8 bits with s_ready[2]=1 → grant[0] at T+1, s_select=3'b100 for 8 cycles, m_ready[0] pulse with resp 00 at T+11.
- m_breq=2'b11 held continuously → grants alternate 0,1,0,1, one idle cycle between transactions.
- Address bits 1,1 (index 3) → no s_select, DONE at T+3 with resp 2'b10.
- With `ARB_TIMEOUT_EN`, s_ready held 0 in DATA → DONE after 15 stall cycles with resp 2'b01; without it, the arbiter stays in DATA.
- Drop m_breq[0] in the 3rd DATA cycle → grant low the next cycle, no m_ready; master 1 is served next.
- Assert reset_n=0 mid-DATA → all outputs 0 immediately; the next request from master 0 is granted first.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin bus arbiter and serial transaction sequencer (IDLE/ADDR/DATA/DONE).
// Define ARB_TIMEOUT_EN to end stalled DATA phases with a timeout error response.
module rr_bus_arbiter #(
    parameter int unsigned N_MASTERS    = 2,
    parameter int unsigned N_SLAVES     = 3,
    parameter int unsigned SLAVE_ADDR_W = 2,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_MASTERS-1:0] m_breq,
    input  logic [N_MASTERS-1:0] m_addr,
    input  logic [N_MASTERS-1:0] m_write,
    input  logic [N_MASTERS-1:0] m_wdata,
    output logic [N_MASTERS-1:0] m_grant,
    output logic [N_MASTERS-1:0] m_rdata,
    output logic [N_MASTERS-1:0] m_ready,
    output logic [1:0]           m_resp,
    output logic [N_SLAVES-1:0]  s_select,
    output logic                 s_write,
    output logic                 s_wdata,
    input  logic [N_SLAVES-1:0]  s_rdata,
    input  logic [N_SLAVES-1:0]  s_ready
);

    localparam int unsigned CUR_W  = $clog2(N_MASTERS);
    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
    localparam int unsigned ACNT_W = $clog2(SLAVE_ADDR_W + 1);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_DEC  = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                  state;
    logic [CUR_W-1:0]        cur;
    logic [CUR_W-1:0]        last;
    logic [SLAVE_ADDR_W-1:0] slave_idx;
    logic [ACNT_W-1:0]       addr_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    write_q;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned STALL_W  = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  RESP_TMO = 2'b01;
    logic [STALL_W-1:0]      stall_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    logic [N_MASTERS-1:0]    req_rot;
    int unsigned             rr_off;
    int unsigned             rr_sum;
    logic                    req_hit;
    logic [CUR_W-1:0]        win;
    logic [N_SLAVES-1:0]     sel_oh;
    logic [SLAVE_ADDR_W-1:0] idx_next;
    logic                    idx_ok;
    logic                    sl_ready;
    logic                    sl_rdata;
    logic                    cur_breq;
    logic                    in_data;

    // Round-robin pick: rotate requests so bit 0 is last+1, take the lowest set bit.
    always_comb begin
        req_rot = N_MASTERS'({m_breq, m_breq} >> (32'(last) + 32'd1));
        req_hit = 1'b0;
        rr_off  = '0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (!req_hit && req_rot[i]) begin
                req_hit = 1'b1;
                rr_off  = 32'(i);
            end
        end
        rr_sum = 32'(last) + 32'd1 + rr_off;
        if (rr_sum >= N_MASTERS) begin
            rr_sum = rr_sum - N_MASTERS;
        end
        win = CUR_W'(rr_sum);
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (slave_idx == SLAVE_ADDR_W'(i)) begin
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign cur_breq = m_breq[cur];
    assign idx_next = SLAVE_ADDR_W'({slave_idx, m_addr[cur]});
    assign idx_ok   = (32'(idx_next) < N_SLAVES);
    assign sl_ready = |(s_ready & sel_oh);
    assign sl_rdata = |(s_rdata & sel_oh);
    assign in_data  = (state == DATA);

    // Data-phase routing is combinational from state and the registered indices.
    assign s_select = in_data ? sel_oh : '0;
    assign s_write  = in_data & write_q;
    assign s_wdata  = in_data & write_q & m_wdata[cur];
    assign m_rdata  = (in_data && !write_q && sl_rdata) ? m_grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur       <= '0;
            last      <= CUR_W'(N_MASTERS - 1);
            slave_idx <= '0;
            addr_cnt  <= '0;
            bit_cnt   <= '0;
            write_q   <= 1'b0;
            m_grant   <= '0;
            m_ready   <= '0;
            m_resp    <= RESP_OKAY;
`ifdef ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
        end else begin
            m_ready <= '0;
            m_resp  <= RESP_OKAY;
            case (state)
                IDLE: begin
                    if (req_hit) begin
                        cur       <= win;
                        m_grant   <= N_MASTERS'(1) << win;
                        slave_idx <= '0;
                        addr_cnt  <= '0;
                        bit_cnt   <= '0;
`ifdef ARB_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (!cur_breq) begin
                        state   <= IDLE;
                        m_grant <= '0;
                        last    <= cur;
                    end else begin
                        slave_idx <= idx_next;
                        addr_cnt  <= addr_cnt + ACNT_W'(1);
                        if (addr_cnt == '0) begin
                            write_q <= m_write[cur];
                        end
                        if (addr_cnt == ACNT_W'(SLAVE_ADDR_W - 1)) begin
                            if (idx_ok) begin
                                state <= DATA;
                            end else begin
                                state   <= DONE;
                                m_ready <= m_grant;
                                m_resp  <= RESP_DEC;
                            end
                        end
                    end
                end
                DATA: begin
                    if (!cur_breq) begin
                        state   <= IDLE;
                        m_grant <= '0;
                        last    <= cur;
                    end else if (sl_ready) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
`ifdef ARB_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            state   <= DONE;
                            m_ready <= m_grant;
                            m_resp  <= RESP_OKAY;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        m_ready <= m_grant;
                        m_resp  <= RESP_TMO;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
`endif
                end
                DONE: begin
                    state   <= IDLE;
                    m_grant <= '0;
                    last    <= cur;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: self-checking bench for rr_bus_arbiter with default parameters.
// Vector table, hand-written corner sequences and randomized transactions against a round-robin model.
module tb_rr_bus_arbiter;

    localparam int N_M = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] m_breq, m_addr, m_write, m_wdata;
    logic [1:0] m_grant, m_rdata, m_ready, m_resp;
    logic [2:0] s_select, s_rdata, s_ready;
    logic       s_write, s_wdata;

    int total = 0;
    int bad   = 0;
    int model_last = N_M - 1;

    rr_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m_breq(m_breq), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata),
        .m_grant(m_grant), .m_rdata(m_rdata), .m_ready(m_ready), .m_resp(m_resp),
        .s_select(s_select), .s_write(s_write), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  breq;
        logic [1:0]  addr;
        logic        wr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int unsigned stall;
        int          exp_win;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tab [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Winner's line carries b, every other master carries the complement.
    function automatic logic [1:0] mix(input logic [1:0] oh, input logic b);
        return (oh & {2{b}}) | (~oh & {2{~b}});
    endfunction

    // Round-robin reference: first requester after the previous owner, with wrap-around.
    function automatic int rr_pick(input logic [1:0] req, input int last);
        for (int k = 1; k <= N_M; k++) begin
            int c;
            c = (last + k) % N_M;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        m_breq = '0; m_addr = '0; m_write = '0; m_wdata = '0;
        s_rdata = '0; s_ready = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_last = N_M - 1;
        tick();
    endtask

    // One complete transaction; caller is inside an IDLE cycle. Data is serial MSB first.
    task automatic run_txn(input logic [1:0] breq, input logic [1:0] addr, input logic wr,
                           input logic [7:0] wd, input logic [7:0] rd, input int unsigned stall,
                           input int exp_win, input logic [1:0] exp_resp);
        logic [1:0] win_oh;
        logic [2:0] slv_oh;
        logic [7:0] got_w, got_r;
        logic       rdy;
        int         nbits, run;
        win_oh = 2'(1) << exp_win;
        slv_oh = 3'(1) << addr;
        m_breq  = breq;
        m_write = mix(win_oh, wr);
        m_addr  = mix(win_oh, addr[1]);
        tick();
        sample();
        chk("grant", 32'(m_grant), 32'(win_oh));
        chk("addr_sel", 32'(s_select), 0);
        chk("addr_resp", 32'({m_ready, m_resp}), 0);
        tick();
        m_addr = mix(win_oh, addr[0]);
        sample();
        chk("grant2", 32'(m_grant), 32'(win_oh));
        chk("addr_sel2", 32'(s_select), 0);
        tick();
        if (exp_resp == 2'b10) begin
            sample();
            chk("dec_ready", 32'(m_ready), 32'(win_oh));
            chk("dec_resp", 32'(m_resp), 32'(exp_resp));
            chk("dec_sel", 32'(s_select), 0);
        end else begin
            nbits = 0; run = 0; got_w = '0; got_r = '0;
            for (int cyc = 0; cyc < 300 && nbits < 8; cyc++) begin
                rdy     = (run >= 4) || ($urandom_range(99) >= stall);
                s_ready = 3'($urandom);
                s_ready = rdy ? (s_ready | slv_oh) : (s_ready & ~slv_oh);
                s_rdata = 3'($urandom);
                s_rdata = rd[7 - nbits] ? (s_rdata | slv_oh) : (s_rdata & ~slv_oh);
                m_wdata = mix(win_oh, wd[7 - nbits]);
                sample();
                chk("data_sel", 32'(s_select), 32'(slv_oh));
                chk("data_wr", 32'(s_write), 32'(wr));
                chk("data_ready", 32'(m_ready), 0);
                chk("rdata_other", 32'(m_rdata & ~win_oh), 0);
                if (rdy) begin
                    if (wr) got_w = {got_w[6:0], s_wdata};
                    else    got_r = {got_r[6:0], |(m_rdata & win_oh)};
                    nbits++;
                    run = 0;
                end else begin
                    run++;
                end
                tick();
            end
            chk("data_bits", 32'(nbits), 8);
            sample();
            chk("done_ready", 32'(m_ready), 32'(win_oh));
            chk("done_resp", 32'(m_resp), 32'(exp_resp));
            chk("done_sel", 32'(s_select), 0);
            if (wr) chk("wdata", 32'(got_w), 32'(wd));
            else    chk("rdata", 32'(got_r), 32'(rd));
        end
        m_breq = '0;
        tick();
        sample();
        chk("idle_grant", 32'(m_grant), 0);
        chk("idle_ready", 32'({m_ready, m_resp}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{2'b01, 2'd2, 1'b1, 8'hA5, 8'h00,  0, 0, 2'b00};
        tab[1] = '{2'b11, 2'd1, 1'b0, 8'h00, 8'h3C, 25, 1, 2'b00};
        tab[2] = '{2'b11, 2'd0, 1'b1, 8'hF0, 8'h00, 25, 0, 2'b00};
        tab[3] = '{2'b01, 2'd3, 1'b1, 8'h11, 8'h00,  0, 0, 2'b10};
        tab[4] = '{2'b10, 2'd2, 1'b0, 8'h00, 8'h96, 30, 1, 2'b00};
        tab[5] = '{2'b11, 2'd0, 1'b0, 8'h00, 8'h5A, 30, 0, 2'b00};
        tab[6] = '{2'b11, 2'd1, 1'b1, 8'hC3, 8'h00, 30, 1, 2'b00};

        do_reset();
        sample();
        chk("rst_grant", 32'(m_grant), 0);
        chk("rst_ready", 32'({m_ready, m_resp}), 0);
        chk("rst_slave", 32'({s_select, s_write, s_wdata}), 0);
        chk("rst_rdata", 32'(m_rdata), 0);

        for (int i = 0; i < 7; i++) begin
            run_txn(tab[i].breq, tab[i].addr, tab[i].wr, tab[i].wd, tab[i].rd,
                    tab[i].stall, tab[i].exp_win, tab[i].exp_resp);
            model_last = tab[i].exp_win;
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0] rq, ad;
            int w;
            rq = 2'($urandom_range(1, 3));
            ad = 2'($urandom_range(0, 3));
            w  = rr_pick(rq, model_last);
            run_txn(rq, ad, 1'($urandom), 8'($urandom), 8'($urandom), 30, w,
                    (ad >= 2'd3) ? 2'b10 : 2'b00);
            model_last = w;
        end

        // Continuous requests from both masters alternate with one idle cycle between.
        do_reset();
        m_breq = 2'b11; m_write = 2'b11; s_ready = 3'b111; m_addr = 2'b11;
        tick();
        for (int t = 0; t < 4; t++) begin
            sample();
            chk("alt_grant", 32'(m_grant), (t % 2 == 0) ? 1 : 2);
            tick();
            m_addr = 2'b00;
            repeat (9) tick();
            sample();
            chk("alt_ready", 32'(m_ready), (t % 2 == 0) ? 1 : 2);
            chk("alt_resp", 32'(m_resp), 0);
            m_addr = 2'b11;
            tick();
            sample();
            chk("alt_idle", 32'(m_grant), 0);
            tick();
        end
        m_breq = '0;
        tick();

        // Slave never ready during DATA.
        do_reset();
        m_breq = 2'b01; m_write = 2'b01; m_addr = 2'b01; s_ready = '0;
        tick();
        tick();
        m_addr = 2'b00;
        tick();
        for (int k = 1; k <= 15; k++) begin
            sample();
            chk("stall_sel", 32'(s_select), 32'(3'b100));
            chk("stall_ready", 32'(m_ready), 0);
            tick();
        end
        sample();
`ifdef ARB_TIMEOUT_EN
        chk("tmo_ready", 32'(m_ready), 1);
        chk("tmo_resp", 32'(m_resp), 1);
`else
        chk("wait_sel", 32'(s_select), 32'(3'b100));
        chk("wait_ready", 32'({m_ready, m_resp}), 0);
`endif
        m_breq = '0;
        tick();
        sample();
        chk("stall_end", 32'({m_grant, s_select}), 0);

        // Master 0 drops its request in the third DATA cycle.
        do_reset();
        m_breq = 2'b11; m_write = 2'b11; m_addr = 2'b11; s_ready = 3'b111;
        tick();
        sample();
        chk("abort_grant0", 32'(m_grant), 1);
        tick();
        m_addr = 2'b00;
        tick();
        tick();
        tick();
        m_breq = 2'b10;
        sample();
        chk("abort_sel", 32'(s_select), 32'(3'b100));
        tick();
        sample();
        chk("abort_grant", 32'(m_grant), 0);
        chk("abort_ready", 32'(m_ready), 0);
        tick();
        sample();
        chk("abort_next", 32'(m_grant), 2);
        chk("abort_noready", 32'(m_ready), 0);
        m_breq = '0;
        tick();
        sample();
        chk("abort2_grant", 32'(m_grant), 0);

        // Reset in the middle of DATA after master 0 owned the bus last.
        tick();
        run_txn(2'b01, 2'd2, 1'b1, 8'h3C, 8'h00, 0, 0, 2'b00);
        m_breq = 2'b01; m_write = 2'b01; m_addr = 2'b11; m_wdata = 2'b11; s_ready = 3'b100;
        tick();
        tick();
        m_addr = 2'b00;
        tick();
        tick();
        sample();
        chk("pre_rst_sel", 32'({s_select, s_wdata}), 32'(4'b1001));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_grant", 32'(m_grant), 0);
        chk("mid_rst_ready", 32'({m_ready, m_resp}), 0);
        chk("mid_rst_slave", 32'({s_select, s_write, s_wdata}), 0);
        chk("mid_rst_rdata", 32'(m_rdata), 0);
        m_breq = 2'b11;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        sample();
        chk("post_rst_grant", 32'(m_grant), 1);
        m_breq = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
